// File: rtl/ucode_loader.sv
// ucode_loader: packs a 32-bit host word stream into 128-bit microcode
// instructions and writes them into SRAM at base + index, stopping at the
// END opcode (0xFF) and reporting the program length.
// Optional feature macro: UCODE_LOADER_CHECKSUM_EN (XOR checksum of host words).
module ucode_loader #(
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_LEN_DEFAULT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base_addr,
  input  logic [15:0]           load_max_len,
  input  logic                  ctrl_busy,
  input  logic                  host_valid,
  input  logic [31:0]           host_data,
  input  logic                  host_last,
  output logic                  host_ready,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [127:0]          sram_wr_data,
  output logic [15:0]           loaded_len,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam logic [7:0] OP_END = 8'hFF;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           limit_q, limit_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            beat_q, beat_d;
  logic [127:0]          inst_q, inst_d;
  logic                  last_q, last_d;
  logic [1:0]            err_q, err_d;
  logic [15:0]           len_q, len_d;
  logic [31:0]           chk_q, chk_d;

  logic xfer;
  assign xfer = host_valid && (state_q == S_COLLECT);

  // Next-state, datapath updates and error flags for the load sequence.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    limit_d = limit_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    inst_d  = inst_q;
    last_d  = last_q;
    err_d   = err_q;
    len_d   = len_q;
    chk_d   = chk_q;
    case (state_q)
      S_IDLE: begin
        if (load_start && !ctrl_busy) begin
          base_d  = load_base_addr;
          limit_d = (load_max_len == 16'd0) ? 16'(MAX_LEN_DEFAULT) : load_max_len;
          idx_d   = 16'd0;
          beat_d  = 2'd0;
          last_d  = 1'b0;
          err_d   = 2'b00;
          chk_d   = 32'd0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          inst_d[{beat_q, 5'd0} +: 32] = host_data;
          chk_d  = chk_q ^ host_data;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            last_d  = host_last;
            state_d = S_WRITE;
          end else if (host_last) begin
            // Program ended mid-instruction: nothing is written for it.
            err_d[1] = 1'b1;
            state_d  = S_FINISH;
          end
        end
      end
      S_WRITE: begin
        idx_d  = idx_q + 16'd1;
        beat_d = 2'd0;
        if (inst_q[7:0] == OP_END) begin
          state_d = S_FINISH;
        end else if (last_q) begin
          err_d[1] = 1'b1;
          state_d  = S_FINISH;
        end else if (({1'b0, idx_q} + 17'd1) == {1'b0, limit_q}) begin
          err_d[0] = 1'b1;
          state_d  = S_FINISH;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_FINISH: begin
        len_d   = idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 16'd0;
      beat_q  <= 2'd0;
      last_q  <= 1'b0;
      err_q   <= 2'b00;
      len_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  // Data-only registers; their outputs are gated by the write strobe.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    limit_q <= limit_d;
    inst_q  <= inst_d;
  end

`ifdef UCODE_LOADER_CHECKSUM_EN
  // Running XOR of every accepted host word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= 32'd0;
    else        chk_q <= chk_d;
  end
  assign checksum = chk_q;
`else
  assign chk_q    = 32'd0;
  assign checksum = 32'd0;
`endif

  assign host_ready   = (state_q == S_COLLECT);
  assign busy         = (state_q != S_IDLE);
  assign sram_wr_en   = (state_q == S_WRITE);
  assign sram_wr_addr = sram_wr_en ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
  assign sram_wr_data = sram_wr_en ? inst_q : 128'd0;
  assign done         = (state_q == S_FINISH) && (err_q == 2'b00);
  assign error        = err_q;
  assign loaded_len   = (state_q == S_FINISH) ? idx_q : len_q;

endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: directed scenarios plus randomized
// programs checked against an instruction-level reference model.
module tb_ucode_loader;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] load_base_addr;
  logic [15:0]   load_max_len;
  logic          ctrl_busy;
  logic          host_valid;
  logic [31:0]   host_data;
  logic          host_last;
  logic          host_ready;
  logic          sram_wr_en;
  logic [AW-1:0] sram_wr_addr;
  logic [127:0]  sram_wr_data;
  logic [15:0]   loaded_len;
  logic          busy;
  logic          done;
  logic [1:0]    error;
  logic [31:0]   checksum;

  always #5 clk = ~clk;

  ucode_loader #(.ADDR_WIDTH(AW), .MAX_LEN_DEFAULT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .load_base_addr(load_base_addr), .load_max_len(load_max_len),
    .ctrl_busy(ctrl_busy), .host_valid(host_valid), .host_data(host_data),
    .host_last(host_last), .host_ready(host_ready), .sram_wr_en(sram_wr_en),
    .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .loaded_len(loaded_len), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]   wq[$];
  bit            lq[$];
  logic [AW-1:0] got_addr[$];
  logic [127:0]  got_data[$];
  int            done_cnt;
  logic [AW-1:0] exp_addr[$];
  logic [127:0]  exp_data[$];
  logic [15:0]   exp_len;
  logic [1:0]    exp_err;
  logic [31:0]   exp_chk;
  int            exp_consumed;
  int            consumed;

  // Capture every SRAM write and done pulse between clock edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_wr_en) begin
        got_addr.push_back(sram_wr_addr);
        got_data.push_back(sram_wr_data);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build n instructions of random words; last one is END if with_end.
  task automatic make_prog(int n, bit with_end);
    logic [31:0] w;
    wq.delete();
    lq.delete();
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) begin
        w = $urandom;
        if (b == 0) begin
          if (with_end && k == n - 1) w[7:0] = 8'hFF;
          else if (w[7:0] == 8'hFF) w[7:0] = 8'h00;
        end
        wq.push_back(w);
        lq.push_back(1'b0);
      end
    end
    lq[lq.size() - 1] = 1'b1;
  endtask

  // Instruction-level reference: what the loader should write and report.
  task automatic model(logic [AW-1:0] base, logic [15:0] maxlen);
    int          limit;
    int          cnt;
    int          pos;
    bit          fin;
    logic [127:0] inst;
    exp_addr.delete();
    exp_data.delete();
    limit   = (maxlen == 16'd0) ? 1024 : int'(maxlen);
    cnt     = 0;
    pos     = 0;
    fin     = 1'b0;
    exp_err = 2'b00;
    exp_chk = 32'd0;
    while (!fin) begin
      inst = '0;
      for (int b = 0; b < 4 && !fin; b++) begin
        if (pos >= wq.size()) begin
          fin = 1'b1;
        end else begin
          inst[b*32 +: 32] = wq[pos];
          exp_chk = exp_chk ^ wq[pos];
          pos++;
          if (lq[pos-1] && b < 3) begin
            exp_err = 2'b10;
            fin = 1'b1;
          end
        end
      end
      if (!fin) begin
        exp_addr.push_back(AW'(int'(base) + cnt));
        exp_data.push_back(inst);
        cnt++;
        if (inst[7:0] == 8'hFF) fin = 1'b1;
        else if (lq[pos-1]) begin exp_err = 2'b10; fin = 1'b1; end
        else if (cnt == limit) begin exp_err = 2'b01; fin = 1'b1; end
      end
    end
    exp_len      = 16'(cnt);
    exp_consumed = pos;
`ifndef UCODE_LOADER_CHECKSUM_EN
    exp_chk = 32'd0;
`endif
  endtask

  // Start a load and stream wq/lq with random valid stalls until idle.
  task automatic run_load(logic [AW-1:0] base, logic [15:0] maxlen, int stall);
    bit rdy;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    consumed = 0;
    @(negedge clk);
    load_base_addr = base;
    load_max_len   = maxlen;
    load_start     = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!busy) break;
      rdy = host_ready;
      if (consumed < wq.size() && $urandom_range(99) >= stall) begin
        host_valid = 1'b1;
        host_data  = wq[consumed];
        host_last  = lq[consumed];
      end else begin
        host_valid = 1'b0;
        host_data  = $urandom;
        host_last  = 1'($urandom);
      end
      if (host_valid && rdy) consumed++;
      @(negedge clk);
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    check("load_timeout_busy", busy, 1'b0);
  endtask

  task automatic compare(string tag);
    int n;
    check({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, "_len"},      loaded_len, exp_len);
    check({tag, "_err"},      error, exp_err);
    check({tag, "_done"},     done_cnt, (exp_err == 2'b00) ? 1 : 0);
    check({tag, "_chk"},      checksum, exp_chk);
    check({tag, "_consumed"}, consumed, exp_consumed);
    check({tag, "_ready"},    host_ready, 1'b0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_ready"}, host_ready, 1'b0);
    check({tag, "_wren"},  sram_wr_en, 1'b0);
    check({tag, "_addr"},  sram_wr_addr, '0);
    check({tag, "_data"},  sram_wr_data, '0);
    check({tag, "_len"},   loaded_len, 16'd0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_err"},   error, 2'b00);
    check({tag, "_chk"},   checksum, 32'd0);
  endtask

  initial begin
    logic [AW-1:0] rbase;
    logic [15:0]   rmax;
    int            rn;
    bit            rend;
    int            wcount;
    rst_n = 1'b0; load_start = 1'b0; load_base_addr = '0; load_max_len = '0;
    ctrl_busy = 1'b0; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // NOP, GEMM, END back-to-back
    make_prog(3, 1'b1);
    wq[0][7:0] = 8'h00;
    wq[4][7:0] = 8'h03;
    model(16'h0100, 16'd0);
    run_load(16'h0100, 16'd0, 0);
    compare("s1");
    check("s1_len3", loaded_len, 16'd3);

    // Same program, host stalls
    run_load(16'h0100, 16'd0, 45);
    compare("s2");

    // Limit of 2, no END
    make_prog(3, 1'b0);
    model(16'h0100, 16'd2);
    run_load(16'h0100, 16'd2, 20);
    compare("s3");
    check("s3_err01", error, 2'b01);

    // host_last on the 6th word
    make_prog(3, 1'b1);
    foreach (lq[i]) lq[i] = 1'b0;
    lq[5] = 1'b1;
    model(16'h0100, 16'd0);
    run_load(16'h0100, 16'd0, 10);
    compare("s4");
    check("s4_len1", loaded_len, 16'd1);

    // load_start blocked by ctrl_busy
    @(negedge clk);
    ctrl_busy = 1'b1; load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    repeat (3) begin
      check("cb_busy", busy, 1'b0);
      check("cb_ready", host_ready, 1'b0);
      @(negedge clk);
    end
    check("cb_err_held", error, 2'b10);
    ctrl_busy = 1'b0;
    make_prog(2, 1'b1);
    model(16'h2000, 16'd0);
    run_load(16'h2000, 16'd0, 30);
    compare("cb_go");

    // Reset during beat 2
    @(negedge clk);
    load_base_addr = 16'h0300; load_max_len = 16'd0; load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    host_valid = 1'b1; host_data = 32'h11111111; host_last = 1'b0;
    @(negedge clk);
    host_data = 32'h22222222;
    @(negedge clk);
    host_data = 32'h33333333;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    wcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (sram_wr_en) wcount++;
    end
    check("rst_mid_nowrites", wcount, 0);
    check("rst_mid_idle", busy, 1'b0);
    host_valid = 1'b0;

    // Checksum words 1,2,4,FF
    wq.delete(); lq.delete();
    wq.push_back(32'h1); wq.push_back(32'h2); wq.push_back(32'h4); wq.push_back(32'hFF);
    lq.push_back(1'b0); lq.push_back(1'b0); lq.push_back(1'b0); lq.push_back(1'b1);
    model(16'h0400, 16'd0);
    run_load(16'h0400, 16'd0, 0);
    compare("s6");
`ifdef UCODE_LOADER_CHECKSUM_EN
    check("s6_chk_f8", checksum, 32'h000000F8);
`else
    check("s6_chk_zero", checksum, 32'd0);
`endif

    // Randomized programs, including address wrap
    for (int t = 0; t < 8; t++) begin
      rbase = (t % 3 == 0) ? 16'hFFFE : 16'($urandom);
      rmax  = 16'($urandom_range(7));
      rn    = $urandom_range(6, 1);
      rend  = 1'($urandom);
      make_prog(rn, rend);
      model(rbase, rmax);
      run_load(rbase, rmax, $urandom_range(60));
      compare($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
